// File: rtl/core_pkg.sv
// Shared core definitions: RegDst/PCSrc encodings, hazard FSM states,
// the ID/EX control bundle and the destination-register resolver.
package core_pkg;

    localparam logic [1:0] REGDST_RD = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;
    localparam logic [1:0] REGDST_K0 = 2'b11;

    localparam logic [2:0] PCSRC_JR = 3'b011;

    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [4:0] REG_K0 = 5'd26;

    typedef enum logic {
        ST_IDLE,
        ST_JR_WAIT
    } hz_state_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regwr;
        logic [1:0] regdst;
        logic       memrd;
        logic       memwr;
    } id_ex_t;

    function automatic logic [4:0] wr_addr(
        input logic [1:0] regdst,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [4:0] a;
        case (regdst)
            REGDST_RD: a = rd;
            REGDST_RT: a = rt;
            REGDST_RA: a = REG_RA;
            default:   a = REG_K0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_hazard_fsm.sv
// Load-use / jump-register hazard detection and stall sequencing.
// A jr fed by a load still in EX needs two stall cycles (IDLE -> JR_WAIT).
module hazard_fsm
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       if_id_use_rt,
    input  logic [2:0] if_id_pcsrc,
    input  logic       id_ex_memrd,
    input  logic [4:0] id_ex_rt,
    input  logic       ex_mem_memrd,
    input  logic [4:0] ex_mem_wraddr,
    input  logic       branch_flush,
    output logic       pc_wr,
    output logic       if_id_wr,
    output logic       stall
);

    hz_state_e state_q;
    hz_state_e state_d;

    logic is_jr;
    logic ex_load;
    logic load_use;
    logic jr_ex;
    logic jr_mem;

    assign is_jr   = (if_id_pcsrc == PCSRC_JR);
    assign ex_load = id_ex_memrd && (id_ex_rt != 5'd0);

    assign load_use = ex_load &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_use_rt && (id_ex_rt == if_id_rt)));

    assign jr_ex = is_jr && ex_load && (id_ex_rt == if_id_rs);

    assign jr_mem = is_jr && ex_mem_memrd &&
                    (ex_mem_wraddr != 5'd0) &&
                    (ex_mem_wraddr == if_id_rs);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        if (branch_flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (jr_ex) begin
                        stall   = 1'b1;
                        state_d = ST_JR_WAIT;
                    end else if (jr_mem || load_use) begin
                        stall = 1'b1;
                    end
                end
                ST_JR_WAIT: begin
                    stall   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pc_wr    = ~stall;
    assign if_id_wr = ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with bubble insertion on stall or branch flush.
// Define HAZARD_STATS_EN to add the Stall_Cnt / Flush_Cnt counters.
module id_ex_hazard_reg
    import core_pkg::*;
#(
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           IF_ID_Rs,
    input  logic [4:0]           IF_ID_Rt,
    input  logic [4:0]           IF_ID_Rd,
    input  logic                 IF_ID_UseRt,
    input  logic                 IF_ID_RegWr,
    input  logic [1:0]           IF_ID_RegDst,
    input  logic                 IF_ID_MemRd,
    input  logic                 IF_ID_MemWr,
    input  logic [2:0]           IF_ID_PCSrc,
    input  logic [PAYLOAD_W-1:0] IF_ID_Payload,
    input  logic                 EX_MEM_MemRd,
    input  logic [4:0]           EX_MEM_WrAddr,
    input  logic                 Branch_Flush,
    output logic [4:0]           ID_EX_Rs,
    output logic [4:0]           ID_EX_Rt,
    output logic [4:0]           ID_EX_Rd,
    output logic                 ID_EX_RegWr,
    output logic [1:0]           ID_EX_RegDst,
    output logic                 ID_EX_MemRd,
    output logic                 ID_EX_MemWr,
    output logic [PAYLOAD_W-1:0] ID_EX_Payload,
    output logic [4:0]           ID_EX_WrAddr,
`ifdef HAZARD_STATS_EN
    output logic [31:0]          Stall_Cnt,
    output logic [31:0]          Flush_Cnt,
`endif
    output logic                 PC_Wr,
    output logic                 IF_ID_Wr,
    output logic                 Stall
);

    id_ex_t               ctl_q;
    id_ex_t               ctl_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] payload_d;
    logic                 bubble;

    hazard_fsm u_hazard_fsm (
        .clk           (clk),
        .reset         (reset),
        .if_id_rs      (IF_ID_Rs),
        .if_id_rt      (IF_ID_Rt),
        .if_id_use_rt  (IF_ID_UseRt),
        .if_id_pcsrc   (IF_ID_PCSrc),
        .id_ex_memrd   (ctl_q.memrd),
        .id_ex_rt      (ctl_q.rt),
        .ex_mem_memrd  (EX_MEM_MemRd),
        .ex_mem_wraddr (EX_MEM_WrAddr),
        .branch_flush  (Branch_Flush),
        .pc_wr         (PC_Wr),
        .if_id_wr      (IF_ID_Wr),
        .stall         (Stall)
    );

    assign bubble = Stall || Branch_Flush;

    always_comb begin
        ctl_d     = '0;
        payload_d = '0;
        if (!bubble) begin
            ctl_d.rs     = IF_ID_Rs;
            ctl_d.rt     = IF_ID_Rt;
            ctl_d.rd     = IF_ID_Rd;
            ctl_d.regwr  = IF_ID_RegWr;
            ctl_d.regdst = IF_ID_RegDst;
            ctl_d.memrd  = IF_ID_MemRd;
            ctl_d.memwr  = IF_ID_MemWr;
            payload_d    = IF_ID_Payload;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q     <= '0;
            payload_q <= '0;
        end else begin
            ctl_q     <= ctl_d;
            payload_q <= payload_d;
        end
    end

    assign ID_EX_Rs      = ctl_q.rs;
    assign ID_EX_Rt      = ctl_q.rt;
    assign ID_EX_Rd      = ctl_q.rd;
    assign ID_EX_RegWr   = ctl_q.regwr;
    assign ID_EX_RegDst  = ctl_q.regdst;
    assign ID_EX_MemRd   = ctl_q.memrd;
    assign ID_EX_MemWr   = ctl_q.memwr;
    assign ID_EX_Payload = payload_q;
    assign ID_EX_WrAddr  = wr_addr(ctl_q.regdst, ctl_q.rt, ctl_q.rd);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, Stall};
        flush_cnt_d = flush_cnt_q + {31'd0, Branch_Flush};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg with a cycle-level reference model.
// Define HAZARD_STATS_EN to also check the stall/flush counters.
module tb_id_ex_hazard_reg;

    localparam int PW = 96;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    IF_ID_Rs = '0;
    logic [4:0]    IF_ID_Rt = '0;
    logic [4:0]    IF_ID_Rd = '0;
    logic          IF_ID_UseRt = 1'b0;
    logic          IF_ID_RegWr = 1'b0;
    logic [1:0]    IF_ID_RegDst = '0;
    logic          IF_ID_MemRd = 1'b0;
    logic          IF_ID_MemWr = 1'b0;
    logic [2:0]    IF_ID_PCSrc = '0;
    logic [PW-1:0] IF_ID_Payload = '0;
    logic          EX_MEM_MemRd = 1'b0;
    logic [4:0]    EX_MEM_WrAddr = '0;
    logic          Branch_Flush = 1'b0;
    logic [4:0]    ID_EX_Rs;
    logic [4:0]    ID_EX_Rt;
    logic [4:0]    ID_EX_Rd;
    logic          ID_EX_RegWr;
    logic [1:0]    ID_EX_RegDst;
    logic          ID_EX_MemRd;
    logic          ID_EX_MemWr;
    logic [PW-1:0] ID_EX_Payload;
    logic [4:0]    ID_EX_WrAddr;
    logic          PC_Wr;
    logic          IF_ID_Wr;
    logic          Stall;
`ifdef HAZARD_STATS_EN
    logic [31:0]   Stall_Cnt;
    logic [31:0]   Flush_Cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_hazard_reg #(.PAYLOAD_W(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .IF_ID_Rd      (IF_ID_Rd),
        .IF_ID_UseRt   (IF_ID_UseRt),
        .IF_ID_RegWr   (IF_ID_RegWr),
        .IF_ID_RegDst  (IF_ID_RegDst),
        .IF_ID_MemRd   (IF_ID_MemRd),
        .IF_ID_MemWr   (IF_ID_MemWr),
        .IF_ID_PCSrc   (IF_ID_PCSrc),
        .IF_ID_Payload (IF_ID_Payload),
        .EX_MEM_MemRd  (EX_MEM_MemRd),
        .EX_MEM_WrAddr (EX_MEM_WrAddr),
        .Branch_Flush  (Branch_Flush),
        .ID_EX_Rs      (ID_EX_Rs),
        .ID_EX_Rt      (ID_EX_Rt),
        .ID_EX_Rd      (ID_EX_Rd),
        .ID_EX_RegWr   (ID_EX_RegWr),
        .ID_EX_RegDst  (ID_EX_RegDst),
        .ID_EX_MemRd   (ID_EX_MemRd),
        .ID_EX_MemWr   (ID_EX_MemWr),
        .ID_EX_Payload (ID_EX_Payload),
        .ID_EX_WrAddr  (ID_EX_WrAddr),
`ifdef HAZARD_STATS_EN
        .Stall_Cnt     (Stall_Cnt),
        .Flush_Cnt     (Flush_Cnt),
`endif
        .PC_Wr         (PC_Wr),
        .IF_ID_Wr      (IF_ID_Wr),
        .Stall         (Stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: what sits in EX, plus forced stall cycles still owed
    logic [4:0]    m_rs, m_rt, m_rd;
    logic          m_regwr, m_memrd, m_memwr;
    logic [1:0]    m_regdst;
    logic [PW-1:0] m_pay;
    int            m_owed;
    logic [31:0]   m_stalls, m_flushes;

    function automatic logic [4:0] m_dest(input logic [1:0] sel,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        logic [4:0] tbl [4];
        tbl[0] = rd;
        tbl[1] = rt;
        tbl[2] = 5'd31;
        tbl[3] = 5'd26;
        return tbl[sel];
    endfunction

    function automatic bit m_jr();
        return IF_ID_PCSrc == 3'b011;
    endfunction

    function automatic bit m_ex_load_hits(input logic [4:0] r);
        return m_memrd && m_rt != 0 && m_rt == r;
    endfunction

    function automatic bit m_stall();
        bit need;
        if (Branch_Flush) return 1'b0;
        if (m_owed > 0) return 1'b1;
        need = m_ex_load_hits(IF_ID_Rs) ||
               (IF_ID_UseRt && m_ex_load_hits(IF_ID_Rt));
        need |= m_jr() && EX_MEM_MemRd && EX_MEM_WrAddr != 0 &&
                EX_MEM_WrAddr == IF_ID_Rs;
        return need;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            {m_rs, m_rt, m_rd, m_regwr, m_memrd, m_memwr, m_regdst} = '0;
            m_pay = '0;
            m_owed = 0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            bit s;
            bit jr_wait;
            s = m_stall();
            jr_wait = !Branch_Flush && m_owed == 0 && m_jr() &&
                      m_ex_load_hits(IF_ID_Rs);
            if (s) m_stalls++;
            if (Branch_Flush) m_flushes++;
            if (s || Branch_Flush) begin
                {m_rs, m_rt, m_rd, m_regwr, m_memrd, m_memwr, m_regdst} = '0;
                m_pay = '0;
            end else begin
                m_rs = IF_ID_Rs;
                m_rt = IF_ID_Rt;
                m_rd = IF_ID_Rd;
                m_regwr = IF_ID_RegWr;
                m_regdst = IF_ID_RegDst;
                m_memrd = IF_ID_MemRd;
                m_memwr = IF_ID_MemWr;
                m_pay = IF_ID_Payload;
            end
            m_owed = jr_wait ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            bit s;
            s = m_stall();
            chk("m_stall", Stall, s);
            chk("m_pc_wr", PC_Wr, !s);
            chk("m_if_id_wr", IF_ID_Wr, !s);
            chk("m_rs", ID_EX_Rs, m_rs);
            chk("m_rt", ID_EX_Rt, m_rt);
            chk("m_rd", ID_EX_Rd, m_rd);
            chk("m_regwr", ID_EX_RegWr, m_regwr);
            chk("m_regdst", ID_EX_RegDst, m_regdst);
            chk("m_memrd", ID_EX_MemRd, m_memrd);
            chk("m_memwr", ID_EX_MemWr, m_memwr);
            chk("m_payload", ID_EX_Payload, m_pay);
            chk("m_wraddr", ID_EX_WrAddr, m_dest(m_regdst, m_rt, m_rd));
`ifdef HAZARD_STATS_EN
            chk("m_stall_cnt", Stall_Cnt, m_stalls);
            chk("m_flush_cnt", Flush_Cnt, m_flushes);
`endif
        end
    end

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit use_rt,
                       input bit regwr, input logic [1:0] regdst,
                       input bit memrd, input bit memwr,
                       input logic [2:0] pcsrc);
        IF_ID_Rs = rs;
        IF_ID_Rt = rt;
        IF_ID_Rd = rd;
        IF_ID_UseRt = use_rt;
        IF_ID_RegWr = regwr;
        IF_ID_RegDst = regdst;
        IF_ID_MemRd = memrd;
        IF_ID_MemWr = memwr;
        IF_ID_PCSrc = pcsrc;
        IF_ID_Payload = {$urandom, $urandom, $urandom};
    endtask

    task automatic lw(input logic [4:0] base, input logic [4:0] dst);
        ins(base, dst, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000);
    endtask

    task automatic add(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
        ins(rs, rt, rd, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic jr(input logic [4:0] rs);
        ins(rs, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b011);
    endtask

    task automatic nop();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memrd", ID_EX_MemRd, 1'b0);
        chk("rst_regwr", ID_EX_RegWr, 1'b0);
        chk("rst_payload", ID_EX_Payload, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_stall", Stall, 1'b0);
        chk("rst_pc_wr", PC_Wr, 1'b1);
        to_next();

        // load-use on rs
        lw(5'd1, 5'd8);
        to_neg(); chk("t1_lw_nostall", Stall, 1'b0); to_next();
        add(5'd8, 5'd2, 5'd3);
        to_neg(); chk("t1_stall", Stall, 1'b1); chk("t1_pc_wr", PC_Wr, 1'b0);
        to_next();
        add(5'd8, 5'd2, 5'd3);
        to_neg(); chk("t1_release", Stall, 1'b0);
        chk("t1_bubble", ID_EX_MemRd, 1'b0); to_next();
        nop();
        to_neg(); chk("t1_add_rs", ID_EX_Rs, 5'd8);
        chk("t1_add_wraddr", ID_EX_WrAddr, 5'd3); to_next();

        // jr behind a load still in EX
        lw(5'd4, 5'd9);
        to_next();
        jr(5'd9);
        to_neg(); chk("t2_stall1", Stall, 1'b1); to_next();
        jr(5'd9);
        to_neg(); chk("t2_stall2", Stall, 1'b1); to_next();
        jr(5'd9);
        to_neg(); chk("t2_issue", Stall, 1'b0); chk("t2_pc_wr", PC_Wr, 1'b1);
        to_next();
        nop();
        to_neg(); chk("t2_jr_rs", ID_EX_Rs, 5'd9); to_next();

        // jr behind a load in MEM
        jr(5'd9);
        EX_MEM_MemRd = 1'b1;
        EX_MEM_WrAddr = 5'd9;
        to_neg(); chk("t3_stall", Stall, 1'b1); to_next();
        EX_MEM_MemRd = 1'b0;
        jr(5'd9);
        to_neg(); chk("t3_once", Stall, 1'b0); to_next();
        EX_MEM_MemRd = 1'b1;
        EX_MEM_WrAddr = 5'd0;
        jr(5'd0);
        to_neg(); chk("t3_r0", Stall, 1'b0); to_next();
        EX_MEM_MemRd = 1'b0;

        // load into $0 never stalls
        lw(5'd1, 5'd0);
        to_next();
        add(5'd0, 5'd0, 5'd7);
        to_neg(); chk("t4_nostall", Stall, 1'b0); to_next();
        nop();
        to_neg(); chk("t4_rd", ID_EX_Rd, 5'd7);
        chk("t4_regwr", ID_EX_RegWr, 1'b1); to_next();

        // store data rt dependency stalls; rt not used as source does not
        lw(5'd2, 5'd5);
        to_next();
        ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000);
        to_neg(); chk("t4_store_stall", Stall, 1'b1); to_next();
        ins(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000);
        to_next();
        lw(5'd2, 5'd5);
        to_next();
        ins(5'd6, 5'd5, 5'd4, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'b000);
        to_neg(); chk("t4_no_use_rt", Stall, 1'b0); to_next();
        ins(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000);
        to_next();
        ins(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 3'b000);
        to_neg(); chk("t4_wr_ra", ID_EX_WrAddr, 5'd31); to_next();
        nop();
        to_neg(); chk("t4_wr_k0", ID_EX_WrAddr, 5'd26); to_next();

        // flush abandons JR_WAIT
        lw(5'd4, 5'd9);
        to_next();
        jr(5'd9);
        to_neg(); chk("t5_stall", Stall, 1'b1); to_next();
        jr(5'd9);
        Branch_Flush = 1'b1;
        to_neg(); chk("t5_flush_stall", Stall, 1'b0);
        chk("t5_flush_pc_wr", PC_Wr, 1'b1);
        chk("t5_flush_if_id_wr", IF_ID_Wr, 1'b1); to_next();
        Branch_Flush = 1'b0;
        add(5'd1, 5'd2, 5'd3);
        to_neg(); chk("t5_after", Stall, 1'b0);
        chk("t5_bubble", ID_EX_Rs, 5'd0); to_next();

        // reset while in JR_WAIT
        lw(5'd4, 5'd9);
        to_next();
        jr(5'd9);
        to_neg(); chk("t6_stall", Stall, 1'b1); to_next();
        jr(5'd9);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_rt", ID_EX_Rt, 5'd0);
        chk("t6_rst_memrd", ID_EX_MemRd, 1'b0);
        chk("t6_rst_regwr", ID_EX_RegWr, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("t6_no_stall", Stall, 1'b0);
`ifdef HAZARD_STATS_EN
        chk("t6_stall_cnt", Stall_Cnt, 32'd0);
`endif
        to_next();
        jr(5'd9);
        to_neg(); chk("t6_jr_free", Stall, 1'b0); to_next();
        nop();
        to_next();
        to_neg();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
